// File: rtl/draw_pkg.sv
// draw_pkg: shared FSM encoding and default VGA screen geometry for draw_region.
//   state_t  : IDLE / DRAW / FLUSH / DONE
//   SCREEN_W : default frame width in pixels
//   SCREEN_H : default frame height in pixels
package draw_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
endpackage

// File: rtl/draw_addr_gen.sv
// draw_addr_gen: col/row scan counters and incremental ROM address for one region.
//   clk, rst      : clock, asynchronous active-high reset
//   load          : latch base/width/height and restart the scan at (0,0)
//   step          : advance one pixel (col fastest)
//   base, width, height : region description sampled on load
//   addr          : base + row*width + col
//   col, row      : current pixel position inside the region
//   last          : current pixel is the final one of the region
module draw_addr_gen #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [7:0]            width,
  input  logic [6:0]            height,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            col,
  output logic [6:0]            row,
  output logic                  last
);
  logic [7:0] w_q;
  logic [6:0] h_q;
  logic       last_col;
  assign last_col = col == w_q - 8'd1;
  assign last     = last_col && row == h_q - 7'd1;
  // Row-major scan with col fastest makes row*width+col a plain pixel index,
  // so the address only ever needs a +1.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_q  <= '0;
      h_q  <= '0;
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (load) begin
      w_q  <= width;
      h_q  <= height;
      addr <= base;
      col  <= '0;
      row  <= '0;
    end else if (step) begin
      addr <= addr + 1'b1;
      col  <= last_col ? 8'd0 : col + 8'd1;
      row  <= last_col ? row + 7'd1 : row;
    end
endmodule

// File: rtl/draw_region.sv
// draw_region: scans a rectangular region, reading pixels from a 1-cycle-latency
// image ROM (or a solid fill colour) and writing them to a VGA adapter with clipping.
//   iClock, iReset          : clock, asynchronous active-high reset
//   iStart                  : draw request, sampled in IDLE
//   iXOrigin, iYOrigin      : screen position of region top-left pixel
//   iWidth, iHeight         : region size (0 means nothing to draw)
//   iImageBase              : ROM address of image pixel (0,0)
//   iFillMode, iFillColour  : solid fill instead of ROM image
//   oAddress, iRomData      : ROM read port
//   oX, oY, oColour, oPlot  : registered pixel write
//   oBusy, oDone            : busy outside IDLE, one-cycle completion pulse
// Build option: define DRAW_REGION_TRANSPARENCY_EN to suppress ROM pixels whose
// colour equals TRANSPARENT_COLOUR.
module draw_region
  import draw_pkg::*;
#(
  parameter int X_SCREEN_PIXELS    = SCREEN_W,
  parameter int Y_SCREEN_PIXELS    = SCREEN_H,
  parameter int COLOUR_WIDTH       = 3,
  parameter int ADDR_WIDTH         = 15,
  parameter int TRANSPARENT_COLOUR = 0
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iStart,
  input  logic [7:0]              iXOrigin,
  input  logic [6:0]              iYOrigin,
  input  logic [7:0]              iWidth,
  input  logic [6:0]              iHeight,
  input  logic [ADDR_WIDTH-1:0]   iImageBase,
  input  logic                    iFillMode,
  input  logic [COLOUR_WIDTH-1:0] iFillColour,
  output logic [ADDR_WIDTH-1:0]   oAddress,
  input  logic [COLOUR_WIDTH-1:0] iRomData,
  output logic [7:0]              oX,
  output logic [6:0]              oY,
  output logic [COLOUR_WIDTH-1:0] oColour,
  output logic                    oPlot,
  output logic                    oBusy,
  output logic                    oDone
);
  localparam logic [8:0] X_LIM = 9'(X_SCREEN_PIXELS);
  localparam logic [7:0] Y_LIM = 8'(Y_SCREEN_PIXELS);
  localparam logic [COLOUR_WIDTH-1:0] KEY = COLOUR_WIDTH'(TRANSPARENT_COLOUR);
`ifdef DRAW_REGION_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif
  state_t state, next;
  logic flush_cnt, load, step, last, v1, on1, key;
  logic fill;
  logic [COLOUR_WIDTH-1:0] fill_c;
  logic [7:0] xo, col, x1;
  logic [6:0] yo, row, y1;
  logic [8:0] x_ext;
  logic [7:0] y_ext;
  draw_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .clk(iClock), .rst(iReset), .load(load), .step(step),
    .base(iImageBase), .width(iWidth), .height(iHeight),
    .addr(oAddress), .col(col), .row(row), .last(last)
  );
  always_ff @(posedge iClock or posedge iReset)
    if (iReset) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
    end else begin
      state     <= next;
      flush_cnt <= state == FLUSH ? ~flush_cnt : 1'b0;
    end
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = !iStart ? IDLE : (iWidth == 8'd0 || iHeight == 7'd0) ? DONE : DRAW;
      DRAW:    next = last ? FLUSH : DRAW;
      FLUSH:   next = flush_cnt ? DONE : FLUSH;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    load  = state == IDLE && iStart;
    step  = state == DRAW;
    oBusy = state != IDLE;
    oDone = state == DONE;
  end
  // Screen coordinates are one bit wider than the ports so that origins near
  // the right/bottom edge clip instead of wrapping back onto the screen.
  assign x_ext = {1'b0, xo} + {1'b0, col};
  assign y_ext = {1'b0, yo} + {1'b0, row};
  assign key   = KEY_EN && !fill && iRomData == KEY;
  // Stage 1 lines up with the ROM read cycle; stage 2 is the output register.
  always_ff @(posedge iClock or posedge iReset)
    if (iReset) begin
      xo      <= '0;
      yo      <= '0;
      fill    <= 1'b0;
      fill_c  <= '0;
      v1      <= 1'b0;
      on1     <= 1'b0;
      x1      <= '0;
      y1      <= '0;
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
    end else begin
      if (load) begin
        xo     <= iXOrigin;
        yo     <= iYOrigin;
        fill   <= iFillMode;
        fill_c <= iFillColour;
      end
      v1    <= step;
      on1   <= x_ext < X_LIM && y_ext < Y_LIM;
      x1    <= x_ext[7:0];
      y1    <= y_ext[6:0];
      oPlot <= v1 && on1 && !key;
      if (v1) begin
        oX      <= x1;
        oY      <= y1;
        oColour <= fill ? fill_c : iRomData;
      end
    end
endmodule

// File: tb/tb_draw_region.sv
// tb_draw_region: randomized and directed regions checked against a pixel-list
// model of draw_region; a ROM with 1-cycle read latency is modelled here.
// Time t counts negedge samples after the edge that takes iStart; the first
// DRAW cycle is t=1, pixel k is addressed at t=k+1 and plotted at t=k+3.
module tb_draw_region;
  logic        iClock = 1'b0;
  logic        iReset, iStart, iFillMode, oPlot, oBusy, oDone;
  logic [7:0]  iXOrigin, iWidth, oX;
  logic [6:0]  iYOrigin, iHeight, oY;
  logic [14:0] iImageBase, oAddress;
  logic [2:0]  iFillColour, iRomData, oColour;
`ifdef DRAW_REGION_TRANSPARENCY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif
  typedef struct packed {int t; int x; int y; int c;} plot_t;
  logic [2:0] rom [0:32767];
  int checks = 0;
  int fails = 0;

  draw_region dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart),
    .iXOrigin(iXOrigin), .iYOrigin(iYOrigin), .iWidth(iWidth), .iHeight(iHeight),
    .iImageBase(iImageBase), .iFillMode(iFillMode), .iFillColour(iFillColour),
    .oAddress(oAddress), .iRomData(iRomData),
    .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iClock = ~iClock;
  always @(posedge iClock) iRomData <= rom[oAddress];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    iXOrigin    = 8'($urandom);
    iYOrigin    = 7'($urandom);
    iWidth      = 8'($urandom);
    iHeight     = 7'($urandom);
    iImageBase  = 15'($urandom);
    iFillMode   = 1'($urandom);
    iFillColour = 3'($urandom);
  endtask

  task automatic run_region(input string name, input int xo, input int yo, input int w,
                            input int h, input int base, input bit fill, input int fc,
                            input bit poke);
    plot_t exp_q[$];
    plot_t obs_q[$];
    int n = w * h;
    int done_t = n > 0 ? n + 3 : 1;
    int addr_bad = 0, busy_bad = 0, done_cnt = 0, done_at = -1, plot_bad = 0;
    for (int k = 0; k < n; k++) begin
      int x = xo + k % w;
      int y = yo + k / w;
      int c = fill ? fc : int'(rom[base + k]);
      if (x < 160 && y < 120 && !(KEY_EN && !fill && c == 0))
        exp_q.push_back(plot_t'{k + 3, x, y, c});
    end
    @(negedge iClock);
    iXOrigin = 8'(xo); iYOrigin = 7'(yo); iWidth = 8'(w); iHeight = 7'(h);
    iImageBase = 15'(base); iFillMode = fill; iFillColour = 3'(fc); iStart = 1'b1;
    for (int t = 1; t <= done_t + 3; t++) begin
      @(negedge iClock);
      scramble_inputs();
      iStart = poke && t == 3;
      if (oPlot) obs_q.push_back(plot_t'{t, int'(oX), int'(oY), int'(oColour)});
      if (t <= n && oAddress !== 15'(base + t - 1)) addr_bad++;
      if (oBusy !== (t <= done_t)) busy_bad++;
      if (oDone === 1'b1) begin done_cnt++; done_at = t; end
    end
    iStart = 1'b0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin
        if (plot_bad == 0)
          $display("%s plot %0d: got t=%0d (%0d,%0d) c=%0d want t=%0d (%0d,%0d) c=%0d", name, i,
                   obs_q[i].t, obs_q[i].x, obs_q[i].y, obs_q[i].c,
                   exp_q[i].t, exp_q[i].x, exp_q[i].y, exp_q[i].c);
        plot_bad++;
      end
    check({name, " addr_errors"}, addr_bad, 0);
    check({name, " busy_errors"}, busy_bad, 0);
    check({name, " done_count"}, done_cnt, 1);
    check({name, " done_time"}, done_at, done_t);
    check({name, " plot_count"}, obs_q.size(), exp_q.size());
    check({name, " plot_errors"}, plot_bad, 0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rom[i] = 3'($urandom);
    for (int i = 300; i < 304; i++) rom[i] = 3'd0;
    iReset = 1'b1; iStart = 1'b0;
    iXOrigin = '0; iYOrigin = '0; iWidth = '0; iHeight = '0;
    iImageBase = '0; iFillMode = 1'b0; iFillColour = '0;
    repeat (2) @(negedge iClock);
    check("reset oAddress", oAddress, 0);
    check("reset oX", oX, 0);
    check("reset oY", oY, 0);
    check("reset oColour", oColour, 0);
    check("reset oPlot", oPlot, 0);
    check("reset oBusy", oBusy, 0);
    check("reset oDone", oDone, 0);
    iReset = 1'b0;
    @(negedge iClock);

    run_region("rom4x2", 10, 5, 4, 2, 100, 1'b0, 0, 1'b0);
    run_region("clip8x4", 156, 118, 8, 4, 200, 1'b0, 0, 1'b0);
    run_region("keyed4x2", 30, 40, 4, 2, 300, 1'b0, 0, 1'b0);
    run_region("fullfill", 0, 0, 160, 120, 0, 1'b1, 4, 1'b0);
    run_region("width0", 3, 3, 0, 5, 50, 1'b0, 0, 1'b0);
    run_region("height0", 3, 3, 5, 0, 50, 1'b1, 2, 1'b0);
    run_region("poke6x3", 70, 60, 6, 3, 1000, 1'b0, 0, 1'b1);
    run_region("single", 159, 119, 1, 1, 7, 1'b0, 0, 1'b1);
    for (int r = 0; r < 8; r++)
      run_region($sformatf("rand%0d", r), int'($urandom_range(0, 200)), int'($urandom_range(0, 127)),
                 int'($urandom_range(1, 24)), int'($urandom_range(1, 12)),
                 int'($urandom_range(0, 20000)), 1'($urandom), int'($urandom_range(0, 7)),
                 1'($urandom));

    // Reset while pixel 5 of a 4x4 region is being addressed.
    begin
      int late_plots = 0, late_busy = 0;
      @(negedge iClock);
      iXOrigin = 8'd20; iYOrigin = 7'd20; iWidth = 8'd4; iHeight = 7'd4;
      iImageBase = 15'd500; iFillMode = 1'b0; iStart = 1'b1;
      @(negedge iClock);
      iStart = 1'b0;
      repeat (5) @(negedge iClock);
      check("midreset addr before", oAddress, 505);
      iReset = 1'b1;
      #1;
      check("midreset oAddress", oAddress, 0);
      check("midreset oX", oX, 0);
      check("midreset oY", oY, 0);
      check("midreset oColour", oColour, 0);
      check("midreset oPlot", oPlot, 0);
      check("midreset oBusy", oBusy, 0);
      check("midreset oDone", oDone, 0);
      @(negedge iClock);
      iReset = 1'b0;
      repeat (12) begin
        @(negedge iClock);
        if (oPlot !== 1'b0) late_plots++;
        if (oBusy !== 1'b0 || oDone !== 1'b0) late_busy++;
      end
      check("midreset later plots", late_plots, 0);
      check("midreset later busy", late_busy, 0);
    end
    run_region("after_reset", 100, 100, 5, 3, 4000, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/draw_region.md
DRAW_REGION -- requirements
Module: draw_region

Interface
REQ-001 SHALL have parameter X_SCREEN_PIXELS, default 160, VGA frame width in pixels.
REQ-002 SHALL have parameter Y_SCREEN_PIXELS, default 120, VGA frame height in pixels.
REQ-003 SHALL have parameter COLOUR_WIDTH, default 3, bits per pixel colour.
REQ-004 SHALL have parameter ADDR_WIDTH, default 15, image ROM address width.
REQ-005 SHALL have parameter TRANSPARENT_COLOUR, default 0, colour key; used only under REQ-030.
REQ-006 SHALL have port iClock  input  1  sole clock, rising edge.
REQ-007 SHALL have port iReset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port iStart  input  1  request to draw one region; sampled in IDLE only.
REQ-009 SHALL have port iXOrigin  input  8  screen x of region top-left pixel.
REQ-010 SHALL have port iYOrigin  input  7  screen y of region top-left pixel.
REQ-011 SHALL have port iWidth  input  8  region width in pixels, 0..X_SCREEN_PIXELS.
REQ-012 SHALL have port iHeight  input  7  region height in pixels, 0..Y_SCREEN_PIXELS.
REQ-013 SHALL have port iImageBase  input  ADDR_WIDTH  ROM address of image pixel (0,0).
REQ-014 SHALL have port iFillMode  input  1  1 = solid fill with iFillColour, 0 = ROM image.
REQ-015 SHALL have port iFillColour  input  COLOUR_WIDTH  solid fill colour.
REQ-016 SHALL have port oAddress  output  ADDR_WIDTH  ROM read address; ROM has 1-cycle synchronous read latency.
REQ-017 SHALL have port iRomData  input  COLOUR_WIDTH  ROM read data.
REQ-018 SHALL have ports oX (8), oY (7), oColour (COLOUR_WIDTH), oPlot (1), all outputs, registered VGA-adapter pixel write.
REQ-019 SHALL have ports oBusy  output  1  high outside IDLE; oDone  output  1  one-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE, DRAW, FLUSH, DONE.
REQ-021 SHALL latch all region inputs at the IDLE edge where iStart=1; change to DRAW with col=row=0, or to DONE if iWidth or iHeight is 0.
REQ-022 SHALL in DRAW present oAddress = iImageBase + row*iWidth + col, built incrementally (no multiplier), one pixel per cycle, col fastest.
REQ-023 SHALL register each pixel's oX/oY/oColour/oPlot exactly 2 cycles after its address is presented; first oPlot follows the 2nd rising edge after entering DRAW.
REQ-024 SHALL move DRAW->FLUSH after the last pixel (col=w-1, row=h-1), FLUSH 2 cycles to drain, then DONE for 1 cycle (oDone=1), then IDLE.
REQ-025 SHALL hold oPlot=0 for pixels with origin+col >= X_SCREEN_PIXELS or origin+row >= Y_SCREEN_PIXELS (clipping); addresses still advance; arithmetic one bit wider than the ports.
REQ-026 SHALL in fill mode output iFillColour (latched) and ignore iRomData; timing is identical.
REQ-027 SHALL ignore iStart outside IDLE; iStart held high through DONE starts a new draw on the IDLE edge.
REQ-028 SHALL keep oPlot=0 in IDLE and DONE; oX/oY/oColour hold their last values.

Reset
REQ-029 SHALL on iReset=1, at any time including mid-draw, force IDLE, counters 0, oAddress=0, oX=0, oY=0, oColour=0, oPlot=0, oBusy=0, oDone=0, and drop in-flight pixels.

Configuration
REQ-030 SHALL with DRAW_REGION_TRANSPARENCY_EN defined, force oPlot=0 for ROM-mode pixels whose iRomData equals TRANSPARENT_COLOUR; without it, every on-screen pixel plots. Fill mode is never keyed.

Structure
REQ-031 SHALL take the state encoding and default screen constants from shared package draw_pkg.
REQ-032 SHALL place the col/row counters and incremental address in sub-module draw_addr_gen.

Verification
REQ-033 SHALL cover: 4x2 ROM region at (10,5), base 100 -> addresses 100..107, 8 plots at (10..13,5..6), first oPlot 2 cycles after DRAW entry, oDone once.
REQ-034 SHALL cover: region 8x4 at (156,118) -> only 4x2 pixels x=156..159, y=118..119 plot; 32 addresses issued.
REQ-035 SHALL cover: fill 160x120 colour 3'b100 -> 19200 plots all colour 4, oBusy high throughout, oDone 19203 cycles after DRAW entry.
REQ-036 SHALL cover: iWidth=0 -> no plots, oDone one cycle after start; iStart mid-draw ignored.
REQ-037 SHALL cover: iReset pulse at pixel 5 of 4x4 -> all outputs 0 next cycle, no further plots; with macro, ROM data 0 -> those pixels unplotted.
